// File: rtl/div11_pkg.sv
// rtl/div11_pkg.sv - shared constants and FSM state type for the divide-by-11 engine
// Purpose: constants shared by the radix-4 divide-by-11 table and sequencer.
// Ports: none (package).
package div11_pkg;

  localparam int DIV11_DIVISOR = 11;
  localparam int DIV11_REM_W   = 4;
  localparam int DIV11_CHUNK_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div11_state_t;

endpackage

// File: rtl/div11_qr_lut6.sv
// rtl/div11_qr_lut6.sv - combinational radix-4 quotient/remainder digit table for divisor 11
// Purpose: maps idx = {rem[3:0], d[1:0]} (value v = 4*rem + d) to qd = v/11 and rem_n = v mod 11.
// Ports:
//   idx   in   6  {running remainder, next two dividend bits}
//   qd    out  2  quotient digit 0..3
//   rem_n out  4  next remainder 0..10
module div11_qr_lut6
  import div11_pkg::*;
(
  input  logic [DIV11_REM_W+DIV11_CHUNK_W-1:0] idx,
  output logic [DIV11_CHUNK_W-1:0]             qd,
  output logic [DIV11_REM_W-1:0]               rem_n
);

  // Each entry is {qd, rem_n}. Because idx is numerically 4*rem + d, the
  // entry index equals v, so the table is just v split into (v/11, v%11).
  // Indices 44..63 need rem >= 11, which the sequencer never produces.
  logic [DIV11_REM_W+DIV11_CHUNK_W-1:0] entry;

  always_comb begin
    entry = '0;
    case (idx)
      6'd0:  entry = 6'h00;  6'd1:  entry = 6'h01;  6'd2:  entry = 6'h02;  6'd3:  entry = 6'h03;
      6'd4:  entry = 6'h04;  6'd5:  entry = 6'h05;  6'd6:  entry = 6'h06;  6'd7:  entry = 6'h07;
      6'd8:  entry = 6'h08;  6'd9:  entry = 6'h09;  6'd10: entry = 6'h0A;  6'd11: entry = 6'h10;
      6'd12: entry = 6'h11;  6'd13: entry = 6'h12;  6'd14: entry = 6'h13;  6'd15: entry = 6'h14;
      6'd16: entry = 6'h15;  6'd17: entry = 6'h16;  6'd18: entry = 6'h17;  6'd19: entry = 6'h18;
      6'd20: entry = 6'h19;  6'd21: entry = 6'h1A;  6'd22: entry = 6'h20;  6'd23: entry = 6'h21;
      6'd24: entry = 6'h22;  6'd25: entry = 6'h23;  6'd26: entry = 6'h24;  6'd27: entry = 6'h25;
      6'd28: entry = 6'h26;  6'd29: entry = 6'h27;  6'd30: entry = 6'h28;  6'd31: entry = 6'h29;
      6'd32: entry = 6'h2A;  6'd33: entry = 6'h30;  6'd34: entry = 6'h31;  6'd35: entry = 6'h32;
      6'd36: entry = 6'h33;  6'd37: entry = 6'h34;  6'd38: entry = 6'h35;  6'd39: entry = 6'h36;
      6'd40: entry = 6'h37;  6'd41: entry = 6'h38;  6'd42: entry = 6'h39;  6'd43: entry = 6'h3A;
      default: entry = 6'h00;
    endcase
  end

  assign qd    = entry[DIV11_REM_W+DIV11_CHUNK_W-1:DIV11_REM_W];
  assign rem_n = entry[DIV11_REM_W-1:0];

endmodule

// File: rtl/div11_seq_r4.sv
// rtl/div11_seq_r4.sv - iterative radix-4 divide-by-11 engine for unsigned dividends
// Purpose: long division by 11, two dividend bits per cycle, MSB first, via div11_qr_lut6.
// Ports:
//   clk       in   1           rising-edge clock
//   rst       in   1           synchronous active-high reset
//   in_valid  in   1           dividend offered
//   in_ready  out  1           engine idle and able to accept
//   in_x      in   DIVIDEND_W  unsigned dividend
//   out_valid out  1           result available, held until accepted
//   out_ready in   1           consumer accepts result
//   out_q     out  DIVIDEND_W  quotient floor(in_x/11)
//   out_r     out  4           remainder in_x mod 11
//   busy      out  1           RUN or DONE
module div11_seq_r4
  import div11_pkg::*;
#(
  parameter int DIVIDEND_W = 64,
  parameter int CHUNK_W    = DIV11_CHUNK_W,
  parameter int DIVISOR    = DIV11_DIVISOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_q,
  output logic [3:0]            out_r,
  output logic                  busy
);

  localparam int ITERS = DIVIDEND_W / CHUNK_W;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [DIV11_REM_W-1:0] REM_MAX  = DIV11_REM_W'(DIVISOR - 1);

  div11_state_t state, state_n;

  logic [CNT_W-1:0]       cnt;
  logic [DIVIDEND_W-1:0]  sh;
  logic [DIVIDEND_W-1:0]  q;
  logic [DIV11_REM_W-1:0] rem;

  logic                   load;
  logic                   iter;
  logic [CHUNK_W-1:0]     qd;
  logic [DIV11_REM_W-1:0] rem_n;

  div11_qr_lut6 u_lut (
    .idx   ({rem, sh[DIVIDEND_W-1 -: CHUNK_W]}),
    .qd    (qd),
    .rem_n (rem_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    iter      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        iter = 1'b1;
        if (cnt == '0) begin
          state_n = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
      q   <= '0;
      rem <= '0;
    end else if (load) begin
      cnt <= CNT_LAST;
      sh  <= in_x;
      q   <= '0;
      rem <= '0;
    end else if (iter) begin
      sh  <= sh << CHUNK_W;
      q   <= {q[DIVIDEND_W-CHUNK_W-1:0], qd};
      rem <= rem_n;
      // The last iteration leaves cnt at zero rather than wrapping.
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // q and rem are only modified in RUN, so they are stable throughout DONE.
  assign out_q = q;
  assign out_r = rem;

  // Table rows above REM_MAX are zero-filled; reaching one means the
  // remainder register was corrupted.
  rem_in_range: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (rem <= REM_MAX));

endmodule

// File: tb/tb_div11_seq_r4.sv
// tb/tb_div11_seq_r4.sv - self-checking bench for div11_seq_r4
module tb_div11_seq_r4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_q;
  logic [3:0]  out_r;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div11_seq_r4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. Expected results come from plain 64-bit / and %.
  // stall: cycles of out_ready=0 once the result is up.
  // junk:  keep in_valid high with a different in_x during RUN (must be ignored).
  // lat:   check the edge at which the consumer first sees out_valid.
  task automatic run_op(input logic [63:0] x, input int stall, input bit junk, input bit lat);
    logic [63:0] eq;
    logic [3:0]  er;
    int n;
    eq = x / 64'd11;
    er = 4'(x % 64'd11);
    in_x     = x;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    step();
    if (junk) begin
      in_x = ~x;
    end else begin
      in_valid = 1'b0;
      in_x     = {$urandom, $urandom};
    end
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
      if (n == 8) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("out_valid_wait", 64'(out_valid), 64'd1);
    // out_valid became visible n edges after the accept edge; the consumer
    // registers it at the following edge.
    if (lat) chk("latency_edges", 64'(n + 1), 64'd33);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_q", out_q, eq);
      chk("stall_r", 64'(out_r), 64'(er));
    end
    chk("quotient", out_q, eq);
    chk("remainder", 64'(out_r), 64'(er));
    chk("busy_done", 64'(busy), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("in_ready_after_accept", 64'(in_ready), 64'd1);
    chk("out_valid_after_accept", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] rx;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_q", out_q, 64'd0);
    chk("rst_out_r", 64'(out_r), 64'd0);

    run_op(64'd0, 0, 1'b0, 1'b1);
    run_op(64'd11, 0, 1'b0, 1'b1);
    run_op(64'd10, 0, 1'b1, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1'b0);
    chk("max_q_const", out_q, 64'h1745_D174_5D17_45D1);
    chk("max_r_const", 64'(out_r), 64'd4);
    run_op(64'h8000_0000_0000_0000, 0, 1'b0, 1'b0);
    chk("msb_q_const", out_q, 64'h0BA2_E8BA_2E8B_A2E8);
    chk("msb_r_const", 64'(out_r), 64'd8);
    run_op(64'd1234567890123, 10, 1'b0, 1'b0);

    // Reset mid-RUN at iteration 15, with in_valid high on the same edge.
    in_x     = 64'd999;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    chk("midrun_busy", 64'(busy), 64'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_x     = 64'd33;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_q", out_q, 64'd0);
    chk("midrst_out_r", 64'(out_r), 64'd0);
    step();
    chk("midrst_no_capture", 64'(busy), 64'd0);
    run_op(64'd22, 0, 1'b0, 1'b1);
    chk("after_rst_q", out_q, 64'd2);

    // Reset while DONE is holding a result.
    in_x     = 64'd77;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (34) step();
    chk("done_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("donerst_out_valid", 64'(out_valid), 64'd0);
    chk("donerst_out_q", out_q, 64'd0);

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       rx = 64'($urandom_range(0, 200));
        1:       rx = {32'hFFFF_FFFF, $urandom};
        default: rx = {$urandom, $urandom};
      endcase
      run_op(rx, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
